ball_physics_engine: RTL

//  Per-frame ball physics and level sequencing for the maze game; generalises the original single-map ball logic.

---
 rtl/ball_physics_engine_if.sv | 21 ++
 rtl/ball_physics_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ball_physics_engine_if.sv
// Collision ROM fetch port: address out, per-axis wall flags back
// one cycle later.
interface ball_physics_engine_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] coll_addr;
  logic              coll_x;
  logic              coll_y;

  modport master (
    output coll_addr,
    input  coll_x,
    input  coll_y
  );

  modport slave (
    input  coll_addr,
    output coll_x,
    output coll_y
  );
endinterface

// File: rtl/ball_physics_engine.sv
// Per-frame ball physics, collision fetch and level sequencing
// for the maze game.
module ball_physics_engine #(
  parameter int COORD_W      = 10,
  parameter int SPEED_W      = 6,
  parameter int H_RES        = 800,
  parameter int V_RES        = 600,
  parameter int ADDR_W       = 19,
  parameter int MAX_SPEED    = 15,
  parameter int DECEL_FRAMES = 5,
  parameter int LEVELS       = 2,
  parameter int START_X      = 400,
  parameter int START_Y      = 300,
  parameter logic [LEVELS*COORD_W-1:0] FINISH_X = {10'd200, 10'd600},
  parameter logic [LEVELS*COORD_W-1:0] FINISH_Y = {10'd150, 10'd400},
  parameter int SLOW_R2      = 144,
  parameter int WIN_R2       = 81,
  parameter int WIN_V2       = 36,
  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic                      pixel_clk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      button_u,
  input  logic                      button_d,
  input  logic                      button_l,
  input  logic                      button_r,
  input  logic                      button_c,
  ball_physics_engine_if.master     coll,
  output logic [LVL_W-1:0]          level,
  output logic [COORD_W-1:0]        ball_x,
  output logic [COORD_W-1:0]        ball_y,
  output logic signed [SPEED_W-1:0] speed_x,
  output logic signed [SPEED_W-1:0] speed_y,
  output logic [COORD_W-1:0]        finish_x,
  output logic [COORD_W-1:0]        finish_y,
  output logic                      victory,
  output logic                      busy
);

  localparam int D_W  = 2*COORD_W + 1;
  localparam int P_W  = COORD_W + 2;
  localparam int V_W  = SPEED_W + 2;
  localparam int DC_W = (DECEL_FRAMES > 1) ? $clog2(DECEL_FRAMES) : 1;

  localparam logic signed [V_W-1:0] ONE  = V_W'(1);
  localparam logic signed [V_W-1:0] VMAX = V_W'(MAX_SPEED);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_UPDATE, S_WIN
  } state_t;

  state_t          state;
  logic [DC_W-1:0] decel_cnt;
  logic            btn_c_q;

  logic signed [SPEED_W-1:0] v1x, v1y;
  logic signed [P_W-1:0]     sx, sy;
  logic [COORD_W-1:0]        nx, ny, dx, dy;
  logic signed [V_W-1:0]     v2x, v2y, v3x, v3y, v4x, v4y;
  logic [V_W-1:0]            ax, ay;
  logic [D_W-1:0]            dist2;
  logic [2*V_W-1:0]          spd2;
  logic                      do_decel, win;

  function automatic logic signed [V_W-1:0] step0(
    input logic signed [V_W-1:0] v
  );
    if (v >= -ONE && v <= ONE) return '0;
    else if (v > 0)            return v - ONE;
    else                       return v + ONE;
  endfunction

  function automatic logic signed [V_W-1:0] clamp(
    input logic signed [V_W-1:0] v
  );
    if (v > VMAX)       return VMAX;
    else if (v < -VMAX) return -VMAX;
    else                return v;
  endfunction

  assign finish_x = FINISH_X[level*COORD_W +: COORD_W];
  assign finish_y = FINISH_Y[level*COORD_W +: COORD_W];

  // Frame update, evaluated from registered state; committed in UPDATE.
  always_comb begin
    v1x = coll.coll_x ? -speed_x : speed_x;
    v1y = coll.coll_y ? -speed_y : speed_y;
    sx  = $signed({2'b00, ball_x}) + P_W'(v1x);
    sy  = $signed({2'b00, ball_y}) + P_W'(v1y);
    nx  = (sx < 0) ? '0 :
          (sx > P_W'(H_RES-1)) ? COORD_W'(H_RES-1) : sx[COORD_W-1:0];
    ny  = (sy < 0) ? '0 :
          (sy > P_W'(V_RES-1)) ? COORD_W'(V_RES-1) : sy[COORD_W-1:0];
    v2x = V_W'(v1x)
        + $signed({{(V_W-1){1'b0}}, button_r})
        - $signed({{(V_W-1){1'b0}}, button_l});
    v2y = V_W'(v1y)
        + $signed({{(V_W-1){1'b0}}, button_d})
        - $signed({{(V_W-1){1'b0}}, button_u});
    dx  = (nx >= finish_x) ? nx - finish_x : finish_x - nx;
    dy  = (ny >= finish_y) ? ny - finish_y : finish_y - ny;
    dist2 = D_W'(dx) * D_W'(dx) + D_W'(dy) * D_W'(dy);
    do_decel = (decel_cnt == '0) || (dist2 < D_W'(SLOW_R2));
    v3x = do_decel ? step0(v2x) : v2x;
    v3y = do_decel ? step0(v2y) : v2y;
    v4x = clamp(v3x);
    v4y = clamp(v3y);
    ax  = (v4x < 0) ? -v4x : v4x;
    ay  = (v4y < 0) ? -v4y : v4y;
    spd2 = (2*V_W)'(ax) * (2*V_W)'(ax) + (2*V_W)'(ay) * (2*V_W)'(ay);
    win = (dist2 < D_W'(WIN_R2)) && (spd2 < (2*V_W)'(WIN_V2));
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      level          <= '0;
      ball_x         <= COORD_W'(START_X);
      ball_y         <= COORD_W'(START_Y);
      speed_x        <= '0;
      speed_y        <= '0;
      decel_cnt      <= '0;
      victory        <= 1'b0;
      busy           <= 1'b0;
      btn_c_q        <= 1'b0;
      coll.coll_addr <= '0;
    end else begin
      btn_c_q <= button_c;
      unique case (state)
        S_IDLE: begin
          if (frame_tick) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          coll.coll_addr <= ADDR_W'(ball_y) * ADDR_W'(H_RES)
                          + ADDR_W'(ball_x);
          state <= S_WAIT;
        end
        S_WAIT: state <= S_UPDATE;
        S_UPDATE: begin
          ball_x    <= nx;
          ball_y    <= ny;
          busy      <= 1'b0;
          decel_cnt <= (decel_cnt == DC_W'(DECEL_FRAMES-1)) ?
                       '0 : decel_cnt + 1'b1;
          if (win) begin
            speed_x <= '0;
            speed_y <= '0;
            victory <= 1'b1;
            state   <= S_WIN;
          end else begin
            speed_x <= v4x[SPEED_W-1:0];
            speed_y <= v4y[SPEED_W-1:0];
            state   <= S_IDLE;
          end
        end
        S_WIN: begin
          // Only a fresh press advances; a held button does not.
          if (button_c && !btn_c_q) begin
            level     <= (level == LVL_W'(LEVELS-1)) ?
                         '0 : level + 1'b1;
            ball_x    <= COORD_W'(START_X);
            ball_y    <= COORD_W'(START_Y);
            speed_x   <= '0;
            speed_y   <= '0;
            decel_cnt <= '0;
            victory   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
